// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle two's-complement adder/subtractor.
// One DIGIT-bit adder slice is reused for WIDTH/DIGIT cycles, least-significant
// chunk first, with the carry held in a register between chunks.
// Start/busy/done handshake; reports carry-out and signed overflow.
// Optional build macro ADDSUB_SATURATE_EN clamps S to the signed range on overflow.
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    // Parameter sanity: reject configurations the chunked datapath cannot cover.
    if (WIDTH < 2) begin : g_bad_width
        $error("addsub_serial: WIDTH must be >= 2");
    end
    if (DIGIT < 1) begin : g_bad_digit
        $error("addsub_serial: DIGIT must be >= 1");
    end
    if ((WIDTH % DIGIT) != 0) begin : g_bad_ratio
        $error("addsub_serial: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Clamp value for an overflowed result, chosen by the sign of operand A.
    function automatic logic [WIDTH-1:0] sat_value(input logic a_sign);
        logic [WIDTH-1:0] v;
        v = {1'b0, {(WIDTH-1){1'b1}}};
        if (a_sign) begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return v;
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;       // already inverted for subtraction
    logic             r_carry;
    logic [KW-1:0]    r_k;
    logic [WIDTH-1:0] r_shadow;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    logic [DIGIT-1:0] w_a_chunk;
    logic [DIGIT-1:0] w_b_chunk;
    logic [DIGIT:0]   w_sum_ext;
    logic [DIGIT-1:0] w_sum;
    logic             w_carry_out;
    logic             w_carry_msb;
    logic             w_ovf;
    logic [WIDTH-1:0] w_merged;
    logic [WIDTH-1:0] w_final;

    // Next-state logic: accept a start in IDLE, leave RUN after the last chunk.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                    w_accept    = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_k == K_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_last      = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Shared adder slice: sum of the current chunk, carries and merged shadow result.
    always_comb begin
        w_a_chunk   = r_a[int'(r_k) * DIGIT +: DIGIT];
        w_b_chunk   = r_b[int'(r_k) * DIGIT +: DIGIT];
        w_sum_ext   = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{DIGIT{1'b0}}, r_carry};
        w_sum       = w_sum_ext[DIGIT-1:0];
        w_carry_out = w_sum_ext[DIGIT];
        // Carry into the top bit of this chunk, recovered from its sum bit.
        w_carry_msb = w_a_chunk[DIGIT-1] ^ w_b_chunk[DIGIT-1] ^ w_sum[DIGIT-1];
        w_ovf       = w_carry_msb ^ w_carry_out;
        w_merged    = r_shadow;
        w_merged[int'(r_k) * DIGIT +: DIGIT] = w_sum;
`ifdef ADDSUB_SATURATE_EN
        if (w_ovf) begin
            w_final = sat_value(r_a[WIDTH-1]);
        end else begin
            w_final = w_merged;
        end
`else
        w_final = w_merged;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered outputs: latch operands, step chunks, publish at completion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_carry  <= 1'b0;
            r_k      <= {KW{1'b0}};
            r_shadow <= {WIDTH{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_s      <= {WIDTH{1'b0}};
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_a     <= A;
                r_b     <= sel ? ~B : B;
                r_carry <= sel;
                r_k     <= {KW{1'b0}};
                r_busy  <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_shadow <= w_merged;
                r_carry  <= w_carry_out;
                if (w_last) begin
                    r_k    <= {KW{1'b0}};
                    r_busy <= 1'b0;
                    r_s    <= w_final;
                    r_cout <= w_carry_out;
                    r_ovf  <= w_ovf;
                end else begin
                    r_k <= r_k + {{(KW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign S    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, multi-cycle two's-complement adder/subtractor; successor to the fixed 4-bit combinational adder/subtractor.
- Processes DIGIT bits per clock, least-significant chunk first, through one shared DIGIT-bit adder slice with a registered carry.
- Start/busy/done handshake; reports signed overflow in addition to carry-out.
- Used wherever area matters more than latency, e.g. datapath ALUs in later labs.

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).
- DIGIT, 1, bits processed per cycle. WIDTH % DIGIT must be 0; elaboration error otherwise.

Ports:
- clk  input  1  single clock; everything is updated on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request a new operation; sampled only when busy=0.
- A  input  WIDTH  operand A, two's complement.
- B  input  WIDTH  operand B, two's complement.
- sel  input  1  0 = A+B, 1 = A-B.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: S, cout and ovf are valid and updated.
- S  output  WIDTH  result, held until the next done.
- cout  output  1  carry out of the MSB. For subtraction, 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0 at a clock edge): busy=0, done=0, S=0, cout=0, ovf=0, state=IDLE. Any in-flight operation is abandoned.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, holds chunk counter k in 0..N-1, where N = WIDTH/DIGIT.
- IDLE -> RUN: on an edge with start=1.
  - Latch A, B and sel into internal registers.
  - Initialise the internal carry to sel.
  - Set k=0 and busy=1.
  - B is inverted internally when sel=1 (A + ~B + 1).
- RUN, each edge:
  - Add chunk k of the latched A, of the latched (B or ~B), and the carry.
  - Store the sum bits in the shadow result and update the carry.
  - Increment k.
- RUN -> IDLE: on the edge that processes chunk N-1. On that same edge:
  - S <= full shadow result.
  - cout <= final carry.
  - ovf <= carry into MSB XOR carry out of MSB.
  - busy <= 0, done <= 1.
- Latency: done is high exactly N cycles after the edge that accepted start.
- With WIDTH=DIGIT (N=1): done rises on the edge after the start edge.
- done is high for exactly one cycle; it deasserts on the next edge unless another operation completes on that edge.
- start while busy=1: ignored, with no effect on the operation in flight. A, B and sel may change freely while busy.
- start=1 in the cycle done=1: accepted (busy=0 in that cycle), giving back-to-back operations with no bubble.
- S, cout and ovf do not change except at completion or reset. Partial sums are never visible on S.
- Arithmetic is modulo 2^WIDTH; there is no sign extension and no width growth.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN
- When defined: if ovf is 1 at completion, S is clamped using A[WIDTH-1]:
  - A[WIDTH-1]=0: S = 0 followed by WIDTH-1 ones (max positive).
  - A[WIDTH-1]=1: S = 1 followed by WIDTH-1 zeros (min negative).
  - ovf is still reported as 1. cout keeps the raw carry.
- When not defined: S is always the wrapped modulo result.
- Timing and handshake are identical in both builds.

Test Plan:
- WIDTH=4, DIGIT=1, start with A=6, B=2, sel=0 -> done 4 cycles after the start edge, S=4'b1000, cout=0, ovf=1, busy=1 for 4 cycles. With ADDSUB_SATURATE_EN: S=4'b0111, ovf=1.
- WIDTH=4, DIGIT=1, back-to-back ops, each start asserted in the done cycle:
  - A=-3, B=-4, sel=0 -> S=4'b1001 (-7), cout=1, ovf=0.
  - then A=2, B=6, sel=1 -> S=4'b1100 (-4), cout=0, ovf=0.
  - then A=-4, B=-4, sel=1 -> S=0, cout=1, ovf=0.
  - Check no idle cycle between operations.
- WIDTH=8, DIGIT=2 (N=4):
  - A=100, B=27, sel=0 -> S=127, ovf=0, done 4 cycles after start.
  - A=100, B=28, sel=0 -> S=8'h80, ovf=1, cout=0.
  - With ADDSUB_SATURATE_EN: S=8'h7F.
- Start ignored while busy: WIDTH=4, A=5, B=-1, sel=1. One cycle later, pulse start with A=0, B=0 and change A, B and sel every cycle -> exactly one done, S=6, cout=0, ovf=0.
- Reset mid-operation: WIDTH=8, DIGIT=1. Start 7+1, then assert rst_n=0 at the 3rd RUN edge -> busy=0, done=0, S=0, cout=0, ovf=0 on that edge. No done afterwards. A fresh start of 7+1 then yields S=8 after 8 cycles.
- WIDTH=DIGIT=4, A=-8, B=1, sel=1 -> done on the edge after the start edge, S=4'b0111, ovf=1, cout=1. With ADDSUB_SATURATE_EN: S=4'b1000.
